rs_fu_share_arb: RTL and testbench
==================================

Name: rs_fu_share_arb

Overview:
- Arbitrates issue requests from NUM_REQ reservation-station banks onto one shared, unpipelined, variable-latency functional unit (divider / CSR unit).
- Only one operation is in flight at a time.
- Keeps the in-flight ROB tag and destination PRN, and produces a registered writeback pulse when the FU completes.
- Sits between the rs_bank issue selection for the shared FU lane and the FU itself. Handles pipe_flush squashing and watchdog detection of a hung FU.

Parameters:
NUM_REQ, 4, number of requesting RS banks
MAX_LAT, 64, FU cycles after which the watchdog fires
CNT_W, $clog2(MAX_LAT)+1, busy-cycle counter width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pipe_flush  in  1  squash all speculative work
rob_head_tag  in  `ROB_WIDTH  tag of the oldest ROB entry
req_valid  in  NUM_REQ  per-bank request for the FU
req_tag  in  NUM_REQ*`ROB_WIDTH  per-bank ROB tag, packed, bank i at [i*`ROB_WIDTH+:`ROB_WIDTH]
req_prn  in  NUM_REQ*`PRF_WIDTH  per-bank destination PRN, packed the same way
req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i]
fu_start  out  1  combinational; FU latches operands this cycle
fu_src_idx  out  $clog2(NUM_REQ)  granted bank index, used as the FU operand mux select
fu_done  in  1  one-cycle FU completion pulse
busy  out  1  an operation is in flight (state != IDLE)
wb_valid  out  1  registered writeback pulse
wb_tag  out  `ROB_WIDTH  ROB tag of the completed operation
wb_prn  out  `PRF_WIDTH  PRN of the completed operation
err  out  1  sticky: watchdog timeout or spurious fu_done

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, inflight tag/prn=0, busy_cnt=0.
  - wb_valid=0, wb_tag=0, wb_prn=0, err=0.
  - req_ready=0 and fu_start=0 during reset.
- States: IDLE, BUSY, DRAIN.
- Grant window (can_grant):
  - Open when state==IDLE, or when state==BUSY & fu_done.
  - Closed whenever pipe_flush=1.
- Selection when can_grant & |req_valid:
  - Head override: any valid bank with req_tag==rob_head_tag wins; the lowest such index wins.
  - Otherwise round-robin: first valid bank at or after rr_ptr, with wrap.
- Grant outputs:
  - req_ready is one-hot.
  - fu_start=|req_ready.
  - fu_src_idx = index of the granted bank; 0 when no grant.
- On a grant:
  - Latch req_tag/req_prn of the granted bank into the inflight registers.
  - rr_ptr <= (idx+1) mod NUM_REQ, updated for head-override grants too.
  - busy_cnt <= 0.
- Transitions:
  - IDLE: grant -> BUSY.
  - BUSY, fu_done & !pipe_flush:
    - Next cycle wb_valid=1, wb_tag/wb_prn = the old inflight values.
    - If a new grant occurs in the same cycle -> stay BUSY (back-to-back, zero bubble); else -> IDLE.
  - BUSY, pipe_flush & !fu_done: -> DRAIN. The FU cannot be aborted.
  - BUSY, pipe_flush & fu_done: -> IDLE, no wb_valid, no grant.
  - DRAIN, fu_done: -> IDLE, no wb_valid. pipe_flush in DRAIN is ignored.
- wb_valid is high for exactly one cycle. wb_tag/wb_prn hold their last value while wb_valid=0.
- Watchdog:
  - busy_cnt increments each cycle in BUSY/DRAIN without fu_done, saturating at MAX_LAT.
  - busy_cnt reaching MAX_LAT sets err.
- fu_done while IDLE is ignored for the FSM and sets err.
- err clears only on reset.
- Requests not granted get no state change; banks hold req_valid until granted.
- Async reset mid-operation returns everything to reset values immediately. FU reset is handled by the FU.

Decomposition:
- Shared package: ROB/PRF width macros (already global) and an arb_state_e enum {IDLE, BUSY, DRAIN}.
- One natural sub-module, rr_pick: a parameterised round-robin picker with inputs req and ptr and a one-hot gnt output. It is reusable by future FU-share arbiters.
- Head-override comparison and FSM live in the top module.

Test Plan:
- Reset, then req_valid=4'b0110, head not matching:
  - cycle 0: req_ready=4'b0010, fu_src_idx=1, busy=1.
  - fu_done after 5 cycles: wb_valid pulse with bank1 tag/prn, then req_ready=4'b0100.
- Fairness: all four banks request continuously with fu_done every 3 cycles -> grant order 0,1,2,3,0, with no bubble between done and the next start.
- Head override: rr_ptr=2, req_valid=4'b1101, req_tag[3]=rob_head_tag=7 -> grant bank 3. rr_ptr becomes 0; next non-head grant is bank 0.
- Flush in BUSY:
  - pipe_flush at cycle 2, fu_done at cycle 6 -> state DRAIN during cycles 3–6, wb_valid never asserted, IDLE at 7, grants resume at 7.
  - Same-cycle flush and fu_done -> no wb, no grant, IDLE next cycle.
- Watchdog: MAX_LAT=8, grant, then never assert fu_done -> err=1 after 8 busy cycles and stays 1. A separate run with fu_done while IDLE -> err=1.
- Reset mid-BUSY: assert rst_n=0 asynchronously between clock edges -> busy, wb_valid, req_ready and err drop to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/rs_fu_share_arb_pkg.sv
// Shared types for the FU-share arbiter: ROB/PRF widths and the arbiter state encoding.
`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif
`ifndef PRF_WIDTH
`define PRF_WIDTH 7
`endif

package rs_fu_share_arb_pkg;
  localparam int unsigned RobW = `ROB_WIDTH;
  localparam int unsigned PrfW = `PRF_WIDTH;

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} arb_state_e;
endpackage

// File: rtl/rs_fu_share_arb_rr_pick.sv
// Round-robin picker: one-hot grant to the first requester at or after ptr, with wrap.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt
);

  logic            found;
  logic [IdxW-1:0] j;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IdxW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_fu_share_arb.sv
// Arbitrates RS-bank issue requests onto one shared unpipelined FU, tracks the single
// in-flight op, emits a registered writeback pulse, squashes on flush, and flags hangs.
module rs_fu_share_arb
  import rs_fu_share_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAX_LAT = 64,
  localparam int unsigned CNT_W = $clog2(MAX_LAT) + 1,
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pipe_flush,
  input  logic [RobW-1:0]         rob_head_tag,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*RobW-1:0] req_tag,
  input  logic [NUM_REQ*PrfW-1:0] req_prn,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    fu_start,
  output logic [IDX_W-1:0]        fu_src_idx,
  input  logic                    fu_done,
  output logic                    busy,
  output logic                    wb_valid,
  output logic [RobW-1:0]         wb_tag,
  output logic [PrfW-1:0]         wb_prn,
  output logic                    err
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [RobW-1:0]    tag_q;
  logic [PrfW-1:0]    prn_q;
  logic [CNT_W-1:0]   cnt_q, cnt_inc;

  logic               can_grant, wb_fire, counting;
  logic [NUM_REQ-1:0] head_hit, head_gnt, rr_gnt, gnt;
  logic [IDX_W-1:0]   gnt_idx, next_ptr;
  logic [RobW-1:0]    gnt_tag;
  logic [PrfW-1:0]    gnt_prn;

  assign can_grant = !pipe_flush &&
                     (state_q == StIdle || (state_q == StBusy && fu_done));

  always_comb begin
    head_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      head_hit[i] = req_valid[i] && (req_tag[i*RobW +: RobW] == rob_head_tag);
    end
  end

  // Isolate the lowest set bit so the lowest-index head match wins.
  assign head_gnt = head_hit & (~head_hit + NUM_REQ'(1));

  rr_pick #(
    .N(NUM_REQ)
  ) u_rr_pick (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .gnt(rr_gnt)
  );

  // rst_n gate keeps the grant quiet while reset is held.
  assign gnt = (can_grant && rst_n) ? ((|head_hit) ? head_gnt : rr_gnt) : '0;

  always_comb begin
    gnt_idx = '0;
    gnt_tag = '0;
    gnt_prn = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = IDX_W'(i);
        gnt_tag = req_tag[i*RobW +: RobW];
        gnt_prn = req_prn[i*PrfW +: PrfW];
      end
    end
  end

  assign req_ready  = gnt;
  assign fu_start   = |gnt;
  assign fu_src_idx = gnt_idx;
  assign busy       = (state_q != StIdle);
  assign next_ptr   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  assign wb_fire  = (state_q == StBusy) && fu_done && !pipe_flush;
  assign counting = (state_q != StIdle) && !fu_done;
  assign cnt_inc  = (cnt_q == CNT_W'(MAX_LAT)) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (fu_start) state_d = StBusy;
      StBusy: begin
        if (fu_done)         state_d = fu_start ? StBusy : StIdle;
        else if (pipe_flush) state_d = StDrain;
      end
      // The FU cannot be aborted, so a squashed op is waited out here.
      StDrain: if (fu_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      tag_q    <= '0;
      prn_q    <= '0;
      cnt_q    <= '0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_prn   <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_valid <= wb_fire;
      if (wb_fire) begin
        wb_tag <= tag_q;
        wb_prn <= prn_q;
      end
      if (fu_start) begin
        tag_q    <= gnt_tag;
        prn_q    <= gnt_prn;
        rr_ptr_q <= next_ptr;
        cnt_q    <= '0;
      end else if (counting) begin
        cnt_q <= cnt_inc;
      end
      if ((counting && cnt_inc == CNT_W'(MAX_LAT)) || (state_q == StIdle && fu_done)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rs_fu_share_arb.sv
// Bench for rs_fu_share_arb: directed scenarios plus random traffic against a cycle-level
// reference model; writebacks are checked by an independent monitor through a queue.
`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif
`ifndef PRF_WIDTH
`define PRF_WIDTH 7
`endif

module tb_rs_fu_share_arb;
  import rs_fu_share_arb_pkg::*;

  localparam int N  = 4;
  localparam int ML = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pipe_flush = 1'b0;
  logic            fu_done = 1'b0;
  logic [RobW-1:0] rob_head_tag = '0;
  logic [N-1:0]    req_valid = '0;
  logic [RobW-1:0] tags [N];
  logic [PrfW-1:0] prns [N];
  logic [N*RobW-1:0] req_tag;
  logic [N*PrfW-1:0] req_prn;

  logic [N-1:0]    req_ready;
  logic            fu_start, busy, wb_valid, err;
  logic [1:0]      fu_src_idx;
  logic [RobW-1:0] wb_tag;
  logic [PrfW-1:0] wb_prn;

  always_comb begin
    req_tag = '0;
    req_prn = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i*RobW +: RobW] = tags[i];
      req_prn[i*PrfW +: PrfW] = prns[i];
    end
  end

  rs_fu_share_arb #(
    .NUM_REQ(N),
    .MAX_LAT(ML)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pipe_flush(pipe_flush),
    .rob_head_tag(rob_head_tag),
    .req_valid(req_valid),
    .req_tag(req_tag),
    .req_prn(req_prn),
    .req_ready(req_ready),
    .fu_start(fu_start),
    .fu_src_idx(fu_src_idx),
    .fu_done(fu_done),
    .busy(busy),
    .wb_valid(wb_valid),
    .wb_tag(wb_tag),
    .wb_prn(wb_prn),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: 0 = idle, 1 = op in flight, 2 = squashed op still in the FU.
  int              m_state, m_ptr, m_cnt, m_gnt;
  logic            m_err;
  logic [RobW-1:0] m_tag;
  logic [PrfW-1:0] m_prn;

  typedef struct {
    logic [RobW-1:0] tag;
    logic [PrfW-1:0] prn;
    int              due;
  } wb_t;
  wb_t             exp_q[$];
  logic [RobW-1:0] last_tag;
  logic [PrfW-1:0] last_prn;

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_cnt = 0; m_gnt = -1; m_err = 1'b0;
    m_tag = '0; m_prn = '0;
    exp_q.delete();
    last_tag = '0; last_prn = '0;
  endtask

  // Called mid-cycle: checks combinational outputs, then advances past the next edge.
  task automatic model_step();
    int g;
    bit can;
    g   = -1;
    can = !pipe_flush && (m_state == 0 || (m_state == 1 && fu_done));
    if (can) begin
      for (int i = 0; i < N; i++)
        if (g < 0 && req_valid[i] && tags[i] == rob_head_tag) g = i;
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("fu_start", 32'(fu_start), 32'(g >= 0));
    check("fu_src_idx", 32'(fu_src_idx), (g >= 0) ? 32'(g) : 32'd0);
    check("busy", 32'(busy), 32'(m_state != 0));
    check("err", 32'(err), 32'(m_err));

    if (m_state == 1 && fu_done && !pipe_flush) exp_q.push_back('{m_tag, m_prn, cyc + 1});
    if (m_state == 0 && fu_done) m_err = 1'b1;
    if (m_state != 0 && !fu_done) begin
      m_cnt = (m_cnt < ML) ? m_cnt + 1 : ML;
      if (m_cnt == ML) m_err = 1'b1;
    end
    if (m_state == 0) m_state = (g >= 0) ? 1 : 0;
    else if (m_state == 1) begin
      if (fu_done) m_state = (g >= 0) ? 1 : 0;
      else if (pipe_flush) m_state = 2;
    end else if (fu_done) m_state = 0;
    if (g >= 0) begin
      m_tag = tags[g]; m_prn = prns[g]; m_ptr = (g + 1) % N; m_cnt = 0;
    end
    m_gnt = g;
  endtask

  // Writeback monitor.
  initial begin
    forever @(negedge clk) begin
      if (rst_n) begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_missing: got no wb_valid, expected tag %0h (cycle %0d)",
                   exp_q[0].tag, cyc);
          void'(exp_q.pop_front());
        end
        if (wb_valid) begin
          if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("wb_tag", 32'(wb_tag), 32'(exp_q[0].tag));
            check("wb_prn", 32'(wb_prn), 32'(exp_q[0].prn));
            last_tag = exp_q[0].tag;
            last_prn = exp_q[0].prn;
            void'(exp_q.pop_front());
          end else begin
            n_cmp++; n_bad++;
            $display("FAIL wb_spurious: got wb_valid=1, expected 0 (cycle %0d)", cyc);
          end
        end else begin
          check("wb_tag_hold", 32'(wb_tag), 32'(last_tag));
          check("wb_prn_hold", 32'(wb_prn), 32'(last_prn));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (m_gnt >= 0) req_valid[m_gnt] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; pipe_flush = 1'b0; fu_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order[$];
    int at_c[$];
    for (int i = 0; i < N; i++) begin
      tags[i] = RobW'(8 + i);
      prns[i] = PrfW'(20 + i);
    end
    model_reset();
    // Held reset with requests pending.
    req_valid = 4'b1111;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_fu_start", 32'(fu_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_tag", 32'(wb_tag), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    do_reset();

    // Basic round-robin grant and writeback.
    req_valid = 4'b0110;
    #1;
    check("t1_ready", 32'(req_ready), 32'b0010);
    check("t1_idx", 32'(fu_src_idx), 32'd1);
    step();
    #1 check("t1_busy", 32'(busy), 32'd1);
    repeat (4) step();
    fu_done = 1'b1;
    #1 check("t1_b2b_ready", 32'(req_ready), 32'b0100);
    step();
    fu_done = 1'b0;
    #1;
    check("t1_wb_valid", 32'(wb_valid), 32'd1);
    check("t1_wb_tag", 32'(wb_tag), 32'd9);
    check("t1_wb_prn", 32'(wb_prn), 32'd21);
    fu_done = 1'b1; step(); fu_done = 1'b0; step();

    // Fairness with zero-bubble back-to-back grants.
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      fu_done = (c > 0 && c % 3 == 0);
      #1;
      if (fu_start) begin
        order.push_back(int'(fu_src_idx));
        at_c.push_back(c);
      end
      step();
      req_valid = 4'b1111;
    end
    check("fair_count", 32'(order.size()), 32'd5);
    for (int k = 0; k < order.size() && k < 5; k++) begin
      check("fair_order", 32'(order[k]), 32'(k % 4));
      check("fair_cycle", 32'(at_c[k]), 32'(3 * k));
    end
    req_valid = '0; fu_done = 1'b1; step(); fu_done = 1'b0;

    // Head override beats round-robin and still advances the pointer.
    do_reset();
    rob_head_tag = '0;
    req_valid = 4'b0010; step();
    fu_done = 1'b1; step(); fu_done = 1'b0;
    tags[0] = 1; tags[2] = 2; tags[3] = 7; rob_head_tag = 7;
    req_valid = 4'b1101;
    #1 check("head_ready", 32'(req_ready), 32'b1000);
    step();
    rob_head_tag = 0; fu_done = 1'b1;
    #1 check("head_next_rr", 32'(req_ready), 32'b0001);
    step();
    fu_done = 1'b0; req_valid = '0;
    fu_done = 1'b1; step(); fu_done = 1'b0;

    // Flush while busy: drain with no writeback, grants resume afterwards.
    do_reset();
    req_valid = 4'b0001;
    step(); step();
    pipe_flush = 1'b1; step(); pipe_flush = 1'b0;
    req_valid = 4'b0010;
    for (int c = 3; c < 6; c++) begin
      pipe_flush = (c == 4);
      #1;
      check("drain_ready", 32'(req_ready), 32'd0);
      check("drain_busy", 32'(busy), 32'd1);
      step();
    end
    pipe_flush = 1'b0; fu_done = 1'b1;
    #1 check("drain_done_ready", 32'(req_ready), 32'd0);
    step(); fu_done = 1'b0;
    #1;
    check("drain_no_wb", 32'(wb_valid), 32'd0);
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_resume", 32'(req_ready), 32'b0010);
    step();
    pipe_flush = 1'b1; fu_done = 1'b1; req_valid = 4'b0100;
    #1 check("flushdone_ready", 32'(req_ready), 32'd0);
    step();
    pipe_flush = 1'b0; fu_done = 1'b0;
    #1;
    check("flushdone_idle", 32'(busy), 32'd0);
    check("flushdone_no_wb", 32'(wb_valid), 32'd0);
    step();
    fu_done = 1'b1; req_valid = '0; step(); fu_done = 1'b0;

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          req_valid[i] = 1'b1;
          tags[i] = RobW'($urandom_range(7, 0));
          prns[i] = PrfW'($urandom);
        end
      end
      rob_head_tag = RobW'($urandom_range(7, 0));
      pipe_flush = ($urandom_range(9, 0) == 0);
      fu_done = (m_state != 0) && ($urandom_range(2, 0) == 0 || m_cnt >= 5);
      step();
    end
    pipe_flush = 1'b0; fu_done = 1'b0;

    // Watchdog on a hung FU.
    do_reset();
    req_valid = 4'b0001; step();
    for (int k = 1; k <= 10; k++) begin
      step();
      #1 check("wd_err", 32'(err), 32'(k >= ML));
    end

    // Spurious fu_done while idle.
    do_reset();
    fu_done = 1'b1; step(); fu_done = 1'b0;
    #1 check("spurious_err", 32'(err), 32'd1);

    // Asynchronous reset between edges while busy with a writeback pulse out.
    req_valid = 4'b0011; step(); step();
    fu_done = 1'b1; step(); fu_done = 1'b0;
    req_valid = 4'b0100; fu_done = 1'b1;
    #1;
    check("pre_rst_wb_valid", 32'(wb_valid), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_ready", 32'(req_ready), 32'b0100);
    check("pre_rst_err", 32'(err), 32'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    check("arst_fu_start", 32'(fu_start), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    do_reset();
    req_valid = 4'b1000; step();
    fu_done = 1'b1; step(); fu_done = 1'b0;
    step(); step();

    check("wb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
